// File: rtl/config_loader_if.sv
// Bus bundle for config_loader: host table writes, run control and the
// registered per-layer configuration outputs. clk/rst stay plain ports.
//
// Write handshake: a table entry moves on a rising edge where wr_valid and
// wr_ready are both high; wr_data must be stable while wr_valid is high, the
// host may drop wr_valid at any time, and wr_ready is the only output that
// reacts combinationally to an input (clr).
interface config_loader_if #(
  parameter int LENROW_W = 4,
  parameter int BLK_W    = 5,
  parameter int FRAME_W  = 3,
  parameter int PATCH_W  = 2,
  parameter int MAX_LAY  = 8
) ();
  localparam int LAY_W = ($clog2(MAX_LAY) < 1) ? 1 : $clog2(MAX_LAY);
  localparam int ENT_W = LENROW_W + 2 * BLK_W + FRAME_W + PATCH_W;

  logic                clr;
  logic                wr_valid;
  logic                wr_ready;
  logic [ENT_W-1:0]    wr_data;
  logic                start;
  logic                layer_done;
  logic [LENROW_W-1:0] CFG_LenRow;
  logic [BLK_W-1:0]    CFG_DepBlk;
  logic [BLK_W-1:0]    CFG_NumBlk;
  logic [FRAME_W-1:0]  CFG_NumFrm;
  logic [PATCH_W-1:0]  CFG_NumPat;
  logic [LAY_W-1:0]    CFG_NumLay;
  logic [LAY_W-1:0]    cfg_layer;
  logic                cfg_valid;
  logic                run_done;
  // FSM state for observation: 0 = IDLE, 1 = RUN, 2 = DONE
  logic [1:0]          fsm_state;

  modport master (
    output clr, wr_valid, wr_data, start, layer_done,
    input  wr_ready, CFG_LenRow, CFG_DepBlk, CFG_NumBlk, CFG_NumFrm,
           CFG_NumPat, CFG_NumLay, cfg_layer, cfg_valid, run_done, fsm_state
  );

  modport slave (
    input  clr, wr_valid, wr_data, start, layer_done,
    output wr_ready, CFG_LenRow, CFG_DepBlk, CFG_NumBlk, CFG_NumFrm,
           CFG_NumPat, CFG_NumLay, cfg_layer, cfg_valid, run_done, fsm_state
  );
endinterface

// File: rtl/config_loader.sv
// config_loader: host-loaded per-layer configuration table that is replayed
// layer by layer during a run. The host fills the table while IDLE, 'start'
// launches a run at layer 0 and each 'layer_done' pulse steps to the next
// entry; after the last layer the run ends with a one-cycle run_done pulse.
//
// Optional feature: define CONFIG_LOADER_LOOP_EN to make the run wrap from
// the last layer back to layer 0 forever (run_done still pulses on each wrap);
// only clr or rst leave RUN in that build. Without the macro the wrap logic
// does not exist.
//
// Write handshake: an entry is taken on a rising edge where wr_valid and
// wr_ready are both high; wr_ready is high only in IDLE, with free table
// space and clr low. All other outputs are registers.
module config_loader #(
  parameter int LENROW_W = 4,
  parameter int BLK_W    = 5,
  parameter int FRAME_W  = 3,
  parameter int PATCH_W  = 2,
  parameter int MAX_LAY  = 8
) (
  input  logic           clk,
  input  logic           rst,
  config_loader_if.slave bus
);
  localparam int LAY_W = ($clog2(MAX_LAY) < 1) ? 1 : $clog2(MAX_LAY);
  localparam int ENT_W = LENROW_W + 2 * BLK_W + FRAME_W + PATCH_W;

  // Field offsets inside a packed table entry (LenRow in the LSBs).
  localparam int OFS_DEPBLK = LENROW_W;
  localparam int OFS_NUMBLK = LENROW_W + BLK_W;
  localparam int OFS_NUMFRM = LENROW_W + 2 * BLK_W;
  localparam int OFS_NUMPAT = LENROW_W + 2 * BLK_W + FRAME_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Table storage; deliberately not reset.
  logic [ENT_W-1:0] table_mem [MAX_LAY];

  // One extra bit so the pointer can express "table full" (== MAX_LAY).
  logic [LAY_W:0]   wr_ptr;
  logic [LAY_W:0]   ptr_after;
  logic [LAY_W-1:0] last_idx;
  logic             wr_ready;
  logic             wr_fire;

  // Decisions made by the next-state logic for the datapath.
  logic             start_go;
  logic             last_hit;
  logic             load_en;
  logic [LAY_W-1:0] load_idx;
  logic [ENT_W-1:0] load_entry;

  // Registered outputs.
  logic [LENROW_W-1:0] cfg_lenrow;
  logic [BLK_W-1:0]    cfg_depblk;
  logic [BLK_W-1:0]    cfg_numblk;
  logic [FRAME_W-1:0]  cfg_numfrm;
  logic [PATCH_W-1:0]  cfg_numpat;
  logic [LAY_W-1:0]    num_lay;
  logic [LAY_W-1:0]    cfg_layer;
  logic                cfg_valid;
  logic                run_done;

  assign wr_ready = (state == IDLE) && (wr_ptr < (LAY_W + 1)'(MAX_LAY)) && !bus.clr;
  assign wr_fire  = bus.wr_valid && wr_ready;

  // A write in the same cycle as start is counted in the layer count.
  assign ptr_after = wr_ptr + (LAY_W + 1)'(wr_fire);
  assign last_idx  = LAY_W'(ptr_after - (LAY_W + 1)'(1));

  // A start that coincides with the very first write must see that write,
  // which is not yet in the table array: forward it.
  assign load_entry = (wr_fire && (wr_ptr == {1'b0, load_idx})) ? bus.wr_data
                                                                : table_mem[load_idx];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle load decisions; clr overrides everything.
  always_comb begin
    state_next = state;
    start_go   = 1'b0;
    last_hit   = 1'b0;
    load_en    = 1'b0;
    load_idx   = '0;
    case (state)
      IDLE: begin
        if (bus.start && (ptr_after != '0)) begin
          start_go   = 1'b1;
          load_en    = 1'b1;
          load_idx   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.layer_done) begin
          if (cfg_layer < num_lay) begin
            load_en  = 1'b1;
            load_idx = cfg_layer + LAY_W'(1);
          end else begin
            last_hit = 1'b1;
`ifdef CONFIG_LOADER_LOOP_EN
            load_en  = 1'b1;
            load_idx = '0;
`else
            state_next = DONE;
`endif
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (bus.clr) begin
      state_next = IDLE;
      start_go   = 1'b0;
      last_hit   = 1'b0;
      load_en    = 1'b0;
    end
  end

  // Table write port; a write cannot land while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      table_mem[wr_ptr[LAY_W-1:0]] <= bus.wr_data;
    end
  end

  // Write pointer, run status and the registered configuration outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      cfg_layer  <= '0;
      cfg_valid  <= 1'b0;
      run_done   <= 1'b0;
      cfg_lenrow <= LENROW_W'(15);
      cfg_depblk <= BLK_W'(31);
      cfg_numblk <= BLK_W'(1);
      cfg_numfrm <= FRAME_W'(7);
      cfg_numpat <= PATCH_W'(0);
      num_lay    <= LAY_W'(7);
    end else begin
      run_done <= last_hit;
      if (bus.clr) begin
        wr_ptr    <= '0;
        cfg_valid <= 1'b0;
      end else begin
        if (wr_fire) begin
          wr_ptr <= ptr_after;
        end
        if (start_go) begin
          num_lay   <= last_idx;
          cfg_valid <= 1'b1;
        end
`ifndef CONFIG_LOADER_LOOP_EN
        if (last_hit) begin
          cfg_valid <= 1'b0;
        end
`endif
        if (load_en) begin
          cfg_layer  <= load_idx;
          cfg_lenrow <= load_entry[LENROW_W-1:0];
          cfg_depblk <= load_entry[OFS_DEPBLK +: BLK_W];
          cfg_numblk <= load_entry[OFS_NUMBLK +: BLK_W];
          cfg_numfrm <= load_entry[OFS_NUMFRM +: FRAME_W];
          cfg_numpat <= load_entry[OFS_NUMPAT +: PATCH_W];
        end
      end
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.CFG_LenRow = cfg_lenrow;
  assign bus.CFG_DepBlk = cfg_depblk;
  assign bus.CFG_NumBlk = cfg_numblk;
  assign bus.CFG_NumFrm = cfg_numfrm;
  assign bus.CFG_NumPat = cfg_numpat;
  assign bus.CFG_NumLay = num_lay;
  assign bus.cfg_layer  = cfg_layer;
  assign bus.cfg_valid  = cfg_valid;
  assign bus.run_done   = run_done;
  assign bus.fsm_state  = state;
endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader. Every cycle goes through one step
// task that drives the inputs, advances a reference model, pushes expected
// table loads into a queue and, after the edge, pops and compares them.
module tb_config_loader;
  localparam int LENROW_W = 4;
  localparam int BLK_W    = 5;
  localparam int FRAME_W  = 3;
  localparam int PATCH_W  = 2;
  localparam int MAX_LAY  = 8;
  localparam int LAY_W    = 3;
  localparam int ENT_W    = LENROW_W + 2 * BLK_W + FRAME_W + PATCH_W;

  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_DONE = 2;

  localparam logic [ENT_W-1:0] RESET_ENT = {2'd0, 3'd7, 5'd1, 5'd31, 4'd15};

  logic clk = 1'b0;
  logic rst;

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  config_loader_if #(
    .LENROW_W(LENROW_W), .BLK_W(BLK_W), .FRAME_W(FRAME_W),
    .PATCH_W(PATCH_W), .MAX_LAY(MAX_LAY)
  ) bus ();

  config_loader #(
    .LENROW_W(LENROW_W), .BLK_W(BLK_W), .FRAME_W(FRAME_W),
    .PATCH_W(PATCH_W), .MAX_LAY(MAX_LAY)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Scoreboard: {layer, entry} expected to appear on the CFG outputs.
  logic [LAY_W+ENT_W-1:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  // Reference model.
  logic [ENT_W-1:0] m_tab [MAX_LAY];
  int               m_cnt;
  int               m_state;
  int               m_cur;
  int               m_numlay;
  bit               m_valid;
  logic [ENT_W-1:0] m_last;
  int               done_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cfg(input string tag, input logic [ENT_W-1:0] e);
    check({tag, ".lenrow"}, 32'(bus.CFG_LenRow), 32'(e[3:0]));
    check({tag, ".depblk"}, 32'(bus.CFG_DepBlk), 32'(e[8:4]));
    check({tag, ".numblk"}, 32'(bus.CFG_NumBlk), 32'(e[13:9]));
    check({tag, ".numfrm"}, 32'(bus.CFG_NumFrm), 32'(e[16:14]));
    check({tag, ".numpat"}, 32'(bus.CFG_NumPat), 32'(e[18:17]));
  endtask

  // Compare all registered outputs with the model after an edge.
  task automatic compare_outputs(input string tag, input bit pushed, input bit exp_done);
    logic [LAY_W+ENT_W-1:0] item;
    if (pushed) begin
      item = exp_q.pop_front();
      check({tag, ".layer"}, 32'(bus.cfg_layer), 32'(item[LAY_W+ENT_W-1:ENT_W]));
      check_cfg(tag, item[ENT_W-1:0]);
      m_last = item[ENT_W-1:0];
    end else begin
      check({tag, ".layer"}, 32'(bus.cfg_layer), 32'(m_cur));
      check_cfg(tag, m_last);
    end
    check({tag, ".state"},    32'(bus.fsm_state),  32'(m_state));
    check({tag, ".valid"},    32'(bus.cfg_valid),  32'(m_valid));
    check({tag, ".run_done"}, 32'(bus.run_done),   32'(exp_done));
    check({tag, ".numlay"},   32'(bus.CFG_NumLay), 32'(m_numlay));
    if (bus.run_done) done_seen++;
  endtask

  function automatic logic [ENT_W-1:0] rand_entry();
    return ENT_W'($urandom());
  endfunction

  function automatic logic [ENT_W-1:0] entry_with_lenrow(input int lenrow);
    logic [ENT_W-1:0] e;
    e      = rand_entry();
    e[3:0] = 4'(lenrow);
    return e;
  endfunction

  // One clock cycle: drive, update model, wait one edge, compare.
  task automatic step(input string tag, input bit do_wr, input logic [ENT_W-1:0] e,
                      input bit do_start, input bit do_done, input bit do_clr);
    bit exp_ready;
    bit pushed;
    bit exp_done;
    pushed   = 1'b0;
    exp_done = 1'b0;
    bus.wr_valid   = do_wr;
    bus.wr_data    = e;
    bus.start      = do_start;
    bus.layer_done = do_done;
    bus.clr        = do_clr;
    exp_ready = (m_state == ST_IDLE) && (m_cnt < MAX_LAY) && !do_clr;
    #1;
    check({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'(exp_ready));
    if (do_clr) begin
      m_cnt   = 0;
      m_state = ST_IDLE;
      m_valid = 1'b0;
    end else begin
      if (do_wr && exp_ready) begin
        m_tab[m_cnt] = e;
        m_cnt++;
      end
      case (m_state)
        ST_IDLE: begin
          if (do_start && m_cnt > 0) begin
            m_state  = ST_RUN;
            m_numlay = m_cnt - 1;
            m_cur    = 0;
            m_valid  = 1'b1;
            exp_q.push_back({LAY_W'(0), m_tab[0]});
            pushed = 1'b1;
          end
        end
        ST_RUN: begin
          if (do_done) begin
            if (m_cur < m_numlay) begin
              m_cur++;
              exp_q.push_back({LAY_W'(m_cur), m_tab[m_cur]});
              pushed = 1'b1;
            end else begin
              exp_done = 1'b1;
`ifdef CONFIG_LOADER_LOOP_EN
              m_cur = 0;
              exp_q.push_back({LAY_W'(0), m_tab[0]});
              pushed = 1'b1;
`else
              m_state = ST_DONE;
              m_valid = 1'b0;
`endif
            end
          end
        end
        default: m_state = ST_IDLE;
      endcase
    end
    @(negedge clk);
    bus.wr_valid   = 1'b0;
    bus.start      = 1'b0;
    bus.layer_done = 1'b0;
    bus.clr        = 1'b0;
    compare_outputs(tag, pushed, exp_done);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    m_cnt    = 0;
    m_state  = ST_IDLE;
    m_cur    = 0;
    m_numlay = 7;
    m_valid  = 1'b0;
    m_last   = RESET_ENT;
    compare_outputs(tag, 1'b0, 1'b0);
    #1;
    check({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'd1);
  endtask

  initial begin
    int done_before;
    rst            = 1'b1;
    bus.clr        = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.start      = 1'b0;
    bus.layer_done = 1'b0;
    done_seen      = 0;

    // Reset values
    do_reset("reset", 2);
    step("ld_idle", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Full run with LenRow 3/5/7, triggers spaced 4 cycles, then a replay
    step("wr0", 1'b1, entry_with_lenrow(3), 1'b0, 1'b0, 1'b0);
    step("wr1", 1'b1, entry_with_lenrow(5), 1'b0, 1'b0, 1'b0);
    step("wr2", 1'b1, entry_with_lenrow(7), 1'b0, 1'b0, 1'b0);
    step("run_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle("run_gap", 3);
    for (int i = 0; i < 3; i++) begin
      step("run_ld", 1'b0, '0, 1'b0, 1'b1, 1'b0);
      idle("run_gap", 3);
    end
    step("replay_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("replay_ld", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle("replay_tail", 2);
    step("clr_a", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Full table: MAX_LAY+2 back-to-back writes, then walk all layers
    for (int i = 0; i < MAX_LAY + 2; i++) step("full_wr", 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
    step("full_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("run_start_ign", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < MAX_LAY; i++) step("full_ld", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle("full_tail", 2);
    step("clr_b", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Empty-table start is ignored
    step("empty_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle("empty_tail", 1);

    // Write+start collision with one entry already loaded
    step("col_wr", 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
    step("col_wr_start", 1'b1, rand_entry(), 1'b1, 1'b0, 1'b0);
    step("col_ld", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("clr_c", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Write+start into an empty table: the new entry is loaded directly
    step("byp_wr_start", 1'b1, rand_entry(), 1'b1, 1'b0, 1'b0);
    step("byp_ld", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle("byp_tail", 2);
    step("clr_d", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Abort by clr at layer 1 (clr also blocks a concurrent write)
    for (int i = 0; i < 3; i++) step("abort_wr", 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
    step("abort_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("abort_ld", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("abort_clr", 1'b1, rand_entry(), 1'b0, 1'b1, 1'b1);
    idle("abort_tail", 3);

    // Abort by rst mid-run
    for (int i = 0; i < 2; i++) step("rst_wr", 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
    step("rst_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("rst_ld", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    do_reset("rst_mid", 1);
    idle("rst_tail", 2);

`ifdef CONFIG_LOADER_LOOP_EN
    // Loop: 2 entries, 5 layer_done pulses -> layers 0,1,0,1,0,1
    for (int i = 0; i < 2; i++) step("loop_wr", 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
    step("loop_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    done_before = done_seen;
    for (int i = 0; i < 5; i++) begin
      step("loop_ld", 1'b0, '0, 1'b0, 1'b1, 1'b0);
      idle("loop_gap", 1);
    end
    check("loop_done_count", 32'(done_seen - done_before), 32'd2);
    step("loop_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
`else
    done_before = 0;
`endif

    check("exp_q_drained", 32'(exp_q.size()), 32'(done_before - done_before));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
